// File: rtl/led_pattern_sequencer.sv
// LED output-register controller: CPU direct writes arbitrated against a
// stepping pattern sequencer (loop or one-shot) with a programmable period.
module led_pattern_sequencer #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 4,
    parameter int PER_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        addr,
    input  logic [31:0]       WD,
    input  logic              WE,
    output logic [31:0]       RD,
    output logic [DATA_W-1:0] out_wd,
    output logic              out_we,
    output logic              busy
);
    localparam int             IDX_W   = $clog2(DEPTH);
    localparam logic [2:0]     LEN_MAX = 3'(DEPTH - 1);
    localparam logic [4:0]     PAT_END = 5'(4 + DEPTH);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                        state, state_nx;
    logic                          en, oneshot, done;
    logic [2:0]                    len_m1;
    logic [PER_W-1:0]              period, cnt, per_m1;
    logic [DEPTH-1:0][DATA_W-1:0]  pat;
    logic [IDX_W-1:0]              idx;

    logic       ctrl_wr, per_wr, dir_wr, pat_wr, pat_hit;
    logic [3:0] pat_off;
    logic [2:0] len_sat;
    logic       last, seq_emit, finish;
    logic       unused_wd;

    assign unused_wd = ^WD;

    // Bus decode
    assign ctrl_wr = WE && (addr == 4'd0);
    assign per_wr  = WE && (addr == 4'd1);
    assign dir_wr  = WE && (addr == 4'd2);
    assign pat_hit = ({1'b0, addr} >= 5'd4) && ({1'b0, addr} < PAT_END);
    assign pat_wr  = WE && pat_hit;
    assign pat_off = addr - 4'd4;

    assign len_sat = (WD[4:2] > LEN_MAX) ? LEN_MAX : WD[4:2];
    assign last    = (idx == len_m1[IDX_W-1:0]);
    // A period of 0 behaves as 1, so the reload value bottoms out at 0
    assign per_m1  = (period == '0) ? '0 : period - PER_W'(1);
    assign busy    = (state == RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // A CPU write to DIRECT or CTRL pre-empts the sequencer's emit for that cycle
    always_comb begin
        state_nx = state;
        seq_emit = 1'b0;
        finish   = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl_wr && WD[0]) state_nx = RUN;
            end
            RUN: begin
                if (ctrl_wr) begin
                    state_nx = WD[0] ? RUN : IDLE;
                end else if (cnt == '0 && !dir_wr) begin
                    seq_emit = 1'b1;
                    if (last && oneshot) begin
                        finish   = 1'b1;
                        state_nx = IDLE;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    // Control/status; one-shot completion drops EN and ONESHOT and raises DONE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b0;
            len_m1  <= '0;
        end else if (ctrl_wr) begin
            en      <= WD[0];
            oneshot <= WD[1];
            len_m1  <= len_sat;
            done    <= 1'b0;
        end else if (finish) begin
            en      <= 1'b0;
            oneshot <= 1'b0;
            done    <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period <= '0;
            pat    <= '0;
        end else begin
            if (per_wr) period <= WD[PER_W-1:0];
            if (pat_wr) pat[pat_off[IDX_W-1:0]] <= WD[DATA_W-1:0];
        end
    end

    // Step pointer and countdown; a held emit leaves both untouched
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx <= '0;
            cnt <= '0;
        end else if (ctrl_wr) begin
            idx <= '0;
            cnt <= '0;
        end else if (seq_emit) begin
            cnt <= per_m1;
            idx <= last ? '0 : idx + IDX_W'(1);
        end else if (state == RUN && cnt != '0) begin
            cnt <= cnt - PER_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_we <= 1'b0;
            out_wd <= '0;
        end else begin
            out_we <= dir_wr | seq_emit;
            if (dir_wr)        out_wd <= WD[DATA_W-1:0];
            else if (seq_emit) out_wd <= pat[idx];
        end
    end

    always_comb begin
        RD = '0;
        if (addr == 4'd0) begin
            RD = {22'b0, done, busy, 3'b0, len_m1, oneshot, en};
        end else if (addr == 4'd1) begin
            RD[PER_W-1:0] = period;
        end else if (pat_hit) begin
            RD[DATA_W-1:0] = pat[pat_off[IDX_W-1:0]];
        end
    end
endmodule
